alu_share_arbiter: RTL and testbench

// - Shares one ALU instance between two requesters, e.g. the EX stage and a

---
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared ALU: latches a request,
// holds it on the ALU for 1 (or MUL_LAT for multiply) cycles, returns the result.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_data1_i,
    input  logic [DATA_W-1:0] req0_data2_i,
    input  logic [2:0]        req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_data1_i,
    input  logic [DATA_W-1:0] req1_data2_i,
    input  logic [2:0]        req1_ctrl_i,
    output logic              rsp0_valid_o,
    input  logic              rsp0_ready_i,
    output logic              rsp1_valid_o,
    input  logic              rsp1_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_zero_o,
    output logic [DATA_W-1:0] alu_data1_o,
    output logic [DATA_W-1:0] alu_data2_o,
    output logic [2:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i,
    output logic              busy_o
);
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [2:0]       OP_MUL  = 3'b011;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             r_state;
    logic               r_last;
    logic               r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_data1;
    logic [DATA_W-1:0]  r_data2;
    logic [2:0]         r_ctrl;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_zero;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic               r_busy;

    logic               w_idle;
    logic               w_gnt;
    logic               w_hs0;
    logic               w_hs1;
    logic               w_rsp_done;
    logic [DATA_W-1:0]  w_sel_data1;
    logic [DATA_W-1:0]  w_sel_data2;
    logic [2:0]         w_sel_ctrl;

    // Requester 1 wins when it is alone, or when both ask and 0 went last.
    assign w_idle      = (r_state == IDLE);
    assign w_gnt       = req1_valid_i & (~req0_valid_i | ~r_last);
    assign w_hs0       = w_idle & req0_valid_i & ~w_gnt;
    assign w_hs1       = w_idle & req1_valid_i & w_gnt;
    assign w_rsp_done  = (r_state == RESP) & (r_grant ? rsp1_ready_i : rsp0_ready_i);

    assign w_sel_data1 = w_gnt ? req1_data1_i : req0_data1_i;
    assign w_sel_data2 = w_gnt ? req1_data2_i : req0_data2_i;
    assign w_sel_ctrl  = w_gnt ? req1_ctrl_i  : req0_ctrl_i;

    assign req0_ready_o = w_hs0;
    assign req1_ready_o = w_hs1;
    assign rsp0_valid_o = r_rsp0_valid;
    assign rsp1_valid_o = r_rsp1_valid;
    assign rsp_data_o   = r_rsp_data;
    assign rsp_zero_o   = r_rsp_zero;
    assign alu_data1_o  = r_data1;
    assign alu_data2_o  = r_data2;
    assign alu_ctrl_o   = r_ctrl;
    assign busy_o       = r_busy;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_grant      <= 1'b0;
            r_cnt        <= '0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_ctrl       <= '0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs0 | w_hs1) begin
                        r_grant <= w_gnt;
                        r_data1 <= w_sel_data1;
                        r_data2 <= w_sel_data2;
                        r_ctrl  <= w_sel_ctrl;
                        r_cnt   <= (w_sel_ctrl == OP_MUL) ? MUL_CNT : '0;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_data   <= alu_data_i;
                        r_rsp_zero   <= alu_zero_i;
                        r_rsp0_valid <= ~r_grant;
                        r_rsp1_valid <= r_grant;
                        r_state      <= RESP;
                    end
                end
                RESP: begin
                    // IDLE is always re-entered before the next grant.
                    if (w_rsp_done) begin
                        r_last       <= r_grant;
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table of single ops plus sequences for arbitration,
// response back-pressure and reset during a multiply; results tracked by a scoreboard.
module tb_alu_share_arbiter;
    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
    logic [DATA_W-1:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [2:0]        req0_ctrl_i, req1_ctrl_i;
    logic              rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i;
    logic [DATA_W-1:0] rsp_data_o, alu_data1_o, alu_data2_o, alu_data_i;
    logic              rsp_zero_o, alu_zero_i, busy_o;
    logic [2:0]        alu_ctrl_o;

    alu_share_arbiter #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i), .alu_zero_i(alu_zero_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Stand-in ALU; its Zero_o flags equal operands (data1 - data2 == 0).
    always_comb begin
        case (alu_ctrl_o)
            3'b000:  alu_data_i = alu_data1_o & alu_data2_o;
            3'b001:  alu_data_i = alu_data1_o | alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b110:  alu_data_i = alu_data1_o - alu_data2_o;
            3'b011:  alu_data_i = alu_data1_o * alu_data2_o;
            default: alu_data_i = '0;
        endcase
        alu_zero_i = (alu_data1_o == alu_data2_o);
    end

    typedef struct {
        logic              gnt;
        logic [DATA_W-1:0] data;
        logic              zero;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int                n;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [2:0]        ctrl;
        logic [DATA_W-1:0] ed;
        logic              ez;
        int                lat;
    } vec_t;
    vec_t tbl[8];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    function automatic logic rdy(input int n);
        return (n == 1) ? req1_ready_o : req0_ready_o;
    endfunction

    function automatic logic rspv(input int n);
        return (n == 1) ? rsp1_valid_o : rsp0_valid_o;
    endfunction

    task automatic drive_req(input int n, input logic v, input logic [DATA_W-1:0] d1,
                             input logic [DATA_W-1:0] d2, input logic [2:0] ctrl);
        if (n == 1) begin
            req1_valid_i = v; req1_data1_i = d1; req1_data2_i = d2; req1_ctrl_i = ctrl;
        end else begin
            req0_valid_i = v; req0_data1_i = d1; req0_data2_i = d2; req0_ctrl_i = ctrl;
        end
    endtask

    task automatic push_exp(input int n, input logic [DATA_W-1:0] ed, input logic ez);
        exp_t e;
        e.gnt = 1'(n); e.data = ed; e.zero = ez;
        sb.push_back(e);
    endtask

    task automatic check_pop(input int n);
        exp_t e;
        if (sb.size() == 0) begin
            timeout("scoreboard_empty");
        end else begin
            e = sb.pop_front();
            check("rsp_grant", 32'(n), 32'(e.gnt));
            check("rsp_data", rsp_data_o, e.data);
            check("rsp_zero", 32'(rsp_zero_o), 32'(e.zero));
        end
    endtask

    task automatic reset_dut();
        rst_i = 1'b0;
        drive_req(0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, '0, '0, '0);
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_rsp_valid", {30'd0, rsp1_valid_o, rsp0_valid_o}, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_alu_ctrl", 32'(alu_ctrl_o), 0);
        rst_i = 1'b1;
    endtask

    // One transaction on requester n with rsp ready held high.
    task automatic do_op(input int n, input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                         input logic [2:0] ctrl, input logic [DATA_W-1:0] ed, input logic ez,
                         input int lat);
        int t_rdy = 0;
        bit ok = 0;
        drive_req(n, 1'b1, d1, d2, ctrl);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            if (rdy(n)) begin ok = 1; t_rdy = cyc; end
        end
        if (!ok) begin
            timeout("req_ready");
            drive_req(n, 1'b0, d1, d2, ctrl);
            return;
        end
        check("other_ready_low", 32'(rdy(1 - n)), 0);
        push_exp(n, ed, ez);
        @(posedge clk_i); #1;
        drive_req(n, 1'b0, ~d1, ~d2, ~ctrl);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            if (rspv(n)) begin
                ok = 1;
            end else begin
                check("alu_ctrl_hold", 32'(alu_ctrl_o), 32'(ctrl));
                check("alu_data1_hold", alu_data1_o, d1);
            end
        end
        if (!ok) begin
            timeout("rsp_valid");
            return;
        end
        check("latency", 32'(cyc - t_rdy), 32'(lat));
        check("other_rsp_low", 32'(rspv(1 - n)), 0);
        check_pop(n);
        @(posedge clk_i); #1;
    endtask

    initial begin
        tbl[0] = '{0, 32'd5,          32'd7,          3'b010, 32'd12,         1'b0, 2};
        tbl[1] = '{1, 32'd6,          32'd7,          3'b011, 32'd42,         1'b0, 1 + MUL_LAT};
        tbl[2] = '{0, 32'd3,          32'd3,          3'b111, 32'd0,          1'b1, 2};
        tbl[3] = '{1, 32'h0000F0F0,   32'h00000FF0,   3'b000, 32'h000000F0,   1'b0, 2};
        tbl[4] = '{0, 32'h0000F000,   32'h0000000F,   3'b001, 32'h0000F00F,   1'b0, 2};
        tbl[5] = '{1, 32'd5,          32'd7,          3'b110, 32'hFFFFFFFE,   1'b0, 2};
        tbl[6] = '{0, 32'h00010000,   32'h00020000,   3'b011, 32'd0,          1'b0, 1 + MUL_LAT};
        tbl[7] = '{1, 32'hFFFFFFFF,   32'd1,          3'b010, 32'd0,          1'b0, 2};

        reset_dut();
        for (int i = 0; i < 8; i++)
            do_op(tbl[i].n, tbl[i].d1, tbl[i].d2, tbl[i].ctrl, tbl[i].ed, tbl[i].ez, tbl[i].lat);

        // Both requesters valid from reset: grants alternate starting with 0.
        begin
            int exp_g[4] = '{0, 1, 0, 1};
            int cnt = 0;
            reset_dut();
            drive_req(0, 1'b1, 32'd1, 32'd1, 3'b010);
            drive_req(1, 1'b1, 32'd10, 32'd5, 3'b001);
            for (int i = 0; i < 60 && cnt < 4; i++) begin
                @(negedge clk_i);
                if (rsp0_valid_o | rsp1_valid_o) check_pop(rsp1_valid_o ? 1 : 0);
                if (req0_ready_o | req1_ready_o) begin
                    check("single_ready", 32'(req0_ready_o & req1_ready_o), 0);
                    check("grant_order", 32'(req1_ready_o), 32'(exp_g[cnt]));
                    if (req1_ready_o) push_exp(1, 32'd15, 1'b0);
                    else              push_exp(0, 32'd2, 1'b1);
                    cnt++;
                end
            end
            if (cnt < 4) timeout("alternation");
            @(posedge clk_i); #1;
            drive_req(0, 1'b0, '0, '0, '0);
            drive_req(1, 1'b0, '0, '0, '0);
            for (int i = 0; i < 20 && sb.size() > 0; i++) begin
                @(negedge clk_i);
                if (rsp0_valid_o | rsp1_valid_o) check_pop(rsp1_valid_o ? 1 : 0);
            end
            if (sb.size() > 0) timeout("alternation_drain");
            @(posedge clk_i); #1;
        end

        // Response held off: result stays stable and req1 waits.
        begin
            bit ok = 0;
            rsp0_ready_i = 1'b0;
            drive_req(0, 1'b1, 32'd9, 32'd9, 3'b110);
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk_i);
                ok = req0_ready_o;
            end
            if (!ok) timeout("hold_req_ready");
            push_exp(0, 32'd0, 1'b1);
            @(posedge clk_i); #1;
            drive_req(0, 1'b0, 32'd1, 32'd2, 3'b010);
            drive_req(1, 1'b1, 32'd2, 32'd2, 3'b010);
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk_i);
                ok = rsp0_valid_o;
            end
            if (!ok) timeout("hold_rsp_valid");
            for (int k = 0; k < 5; k++) begin
                check("hold_valid", 32'(rsp0_valid_o), 1);
                check("hold_data", rsp_data_o, 0);
                check("hold_zero", 32'(rsp_zero_o), 1);
                check("hold_req1_blocked", 32'(req1_ready_o), 0);
                @(negedge clk_i);
            end
            check_pop(0);
            rsp0_ready_i = 1'b1;
            @(posedge clk_i); #1;
            do_op(1, 32'd2, 32'd2, 3'b010, 32'd4, 1'b1, 2);
        end

        // Reset in the middle of a multiply drops it without a response.
        begin
            bit ok = 0;
            int seen = 0;
            drive_req(1, 1'b1, 32'd6, 32'd7, 3'b011);
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk_i);
                ok = req1_ready_o;
            end
            if (!ok) timeout("mid_reset_ready");
            @(posedge clk_i); #1;
            drive_req(1, 1'b0, '0, '0, '0);
            @(negedge clk_i);
            check("mid_busy", 32'(busy_o), 1);
            rst_i = 1'b0;
            #1;
            check("mid_rst_busy", 32'(busy_o), 0);
            check("mid_rst_valid", {30'd0, rsp1_valid_o, rsp0_valid_o}, 0);
            check("mid_rst_alu_ctrl", 32'(alu_ctrl_o), 0);
            check("mid_rst_alu_data", alu_data1_o | alu_data2_o, 0);
            check("mid_rst_rsp", rsp_data_o, 0);
            @(posedge clk_i); #1;
            rst_i = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk_i);
                if (rsp0_valid_o | rsp1_valid_o) seen++;
            end
            check("no_rsp_after_reset", 32'(seen), 0);
            @(posedge clk_i); #1;
            do_op(0, 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
